// File: rtl/line_clear_ctrl_pkg.sv
// Shared types and constants for the line-clear engine.
//   block_color  : 3-bit cell colour, EMPTY = 0
//   board_row_t  : one playfield row, X_SIZE cells
//   X_SIZE, Y_SIZE, ROW_W : board geometry and row address width
//   ST_*         : controller state encodings
//   empty_row()  : a row with every cell EMPTY
package line_clear_ctrl_pkg;

    localparam int X_SIZE = 10;
    localparam int Y_SIZE = 20;
    localparam int ROW_W  = 5;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        CYAN   = 3'd1,
        YELLOW = 3'd2,
        PURPLE = 3'd3,
        GREEN  = 3'd4,
        RED    = 3'd5,
        BLUE   = 3'd6,
        ORANGE = 3'd7
    } block_color;

    typedef block_color [X_SIZE-1:0] board_row_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic board_row_t empty_row();
        board_row_t r;
        for (int i = 0; i < X_SIZE; i++) begin
            r[i] = EMPTY;
        end
        return r;
    endfunction

endpackage

// File: rtl/line_clear_ctrl_row_full_detect.sv
// Combinational full-row detector.
//   row_i  : one board row
//   full_o : 1 when every cell of row_i is not EMPTY
module row_full_detect
    import line_clear_ctrl_pkg::*;
(
    input  board_row_t row_i,
    output logic       full_o
);

    always_comb begin
        full_o = 1'b1;
        for (int i = 0; i < X_SIZE; i++) begin
            if (row_i[i] == EMPTY) begin
                full_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/line_clear_ctrl.sv
// Sequential line-clear engine. Scans the board bottom to top one row per
// cycle, drops full rows, compacts the survivors downward and refills the
// vacated top rows with EMPTY.
//   Clk, Reset     : clock, asynchronous active-high reset
//   start          : one-cycle pass request, sampled only in IDLE
//   busy           : high while a pass is running (SCAN, FILL, DONE)
//   done           : one-cycle pulse when the board is consistent again
//   rd_row/rd_data : board read port, data returns one cycle after address
//   wr_en/wr_row/wr_data : board write port
//   lines_cleared  : rows removed by the last pass, valid from done
//   total_lines    : saturating running total of lines_cleared
// Handshake: start is a request pulse with no ready; it is only honoured
// when busy is low, otherwise it is dropped. done closes the pass.
module line_clear_ctrl
    import line_clear_ctrl_pkg::*;
#(
    parameter int CNT_W = 16  // assumed >= ROW_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [ROW_W-1:0] rd_row,
    input  board_row_t       rd_data,
    output logic             wr_en,
    output logic [ROW_W-1:0] wr_row,
    output board_row_t       wr_data,
    output logic [ROW_W-1:0] lines_cleared,
    output logic [CNT_W-1:0] total_lines
);

    logic [1:0]       state_q,   state_d;
    logic [ROW_W-1:0] rd_row_q,  rd_row_d;
    logic             iss_q,     iss_d;      // a read is being issued this cycle
    logic [ROW_W-1:0] src_q,     src_d;      // row whose data is on rd_data
    logic             src_vld_q, src_vld_d;
    logic [ROW_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [ROW_W-1:0] count_q,   count_d;
    logic [ROW_W-1:0] lines_q,   lines_d;
    logic [CNT_W-1:0] total_q,   total_d;
    logic [CNT_W:0]   sum;
    logic             row_full;

    row_full_detect u_full (
        .row_i  (rd_data),
        .full_o (row_full)
    );

    always_comb begin
        state_d   = state_q;
        rd_row_d  = rd_row_q;
        iss_d     = iss_q;
        src_d     = src_q;
        src_vld_d = src_vld_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        lines_d   = lines_q;
        total_d   = total_q;
        sum       = '0;
        wr_en     = 1'b0;
        wr_data   = empty_row();

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SCAN;
                    rd_row_d  = ROW_W'(Y_SIZE - 1);
                    iss_d     = 1'b1;
                    src_vld_d = 1'b0;
                    wr_ptr_d  = ROW_W'(Y_SIZE - 1);
                    count_d   = '0;
                end
            end

            ST_SCAN: begin
                // Issue stage: walk rd_row up to row 0 and then hold it.
                src_d     = rd_row_q;
                src_vld_d = iss_q;
                if (iss_q) begin
                    if (rd_row_q == '0) begin
                        iss_d = 1'b0;
                    end else begin
                        rd_row_d = rd_row_q - 1'b1;
                    end
                end

                // Evaluate stage: rd_data belongs to src_q.
                if (src_vld_q) begin
                    if (row_full) begin
                        count_d = count_q + 1'b1;
                    end else begin
                        wr_en   = (src_q != wr_ptr_q);
                        wr_data = rd_data;
                        if (wr_ptr_q != '0) begin
                            wr_ptr_d = wr_ptr_q - 1'b1;
                        end
                    end
                    if (src_q == '0) begin
                        state_d = (count_d == '0) ? ST_DONE : ST_FILL;
                    end
                end
            end

            // After the scan wr_ptr sits exactly at count-1, the lowest
            // vacated row, so it doubles as the fill pointer.
            ST_FILL: begin
                wr_en = 1'b1;
                if (wr_ptr_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    wr_ptr_d = wr_ptr_q - 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Results are published on entry to DONE so they are valid with done.
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            lines_d = count_d;
            sum     = {1'b0, total_q} + (CNT_W + 1)'(count_d);
            total_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            rd_row_q  <= '0;
            iss_q     <= 1'b0;
            src_q     <= '0;
            src_vld_q <= 1'b0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            lines_q   <= '0;
            total_q   <= '0;
        end else begin
            state_q   <= state_d;
            rd_row_q  <= rd_row_d;
            iss_q     <= iss_d;
            src_q     <= src_d;
            src_vld_q <= src_vld_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            lines_q   <= lines_d;
            total_q   <= total_d;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign rd_row        = rd_row_q;
    assign wr_row        = wr_ptr_q;
    assign lines_cleared = lines_q;
    assign total_lines   = total_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Testbench for line_clear_ctrl: board memory model with registered read,
// table of board patterns with expected clear counts / latency / totals,
// write scoreboard, and hand-written start-while-busy and mid-pass reset
// sequences.
module tb_line_clear_ctrl;
    import line_clear_ctrl_pkg::*;

    localparam int TB_CNT_W = 5;
    localparam int EW       = ROW_W + X_SIZE * 3;

    logic                Clk;
    logic                Reset;
    logic                start;
    logic                busy;
    logic                done;
    logic [ROW_W-1:0]    rd_row;
    board_row_t          rd_data;
    logic                wr_en;
    logic [ROW_W-1:0]    wr_row;
    board_row_t          wr_data;
    logic [ROW_W-1:0]    lines_cleared;
    logic [TB_CNT_W-1:0] total_lines;

    line_clear_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .rd_row        (rd_row),
        .rd_data       (rd_data),
        .wr_en         (wr_en),
        .wr_row        (wr_row),
        .wr_data       (wr_data),
        .lines_cleared (lines_cleared),
        .total_lines   (total_lines)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- board memory model ----------------
    board_row_t board      [Y_SIZE];
    board_row_t init_board [Y_SIZE];
    board_row_t exp_board  [Y_SIZE];
    logic       load;

    always @(posedge Clk) begin
        rd_data <= board[rd_row];
        if (load) begin
            board <= init_board;
        end else if (wr_en) begin
            board[wr_row] <= wr_data;
        end
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int checks;
    int errors;

    always @(negedge Clk) begin
        if (!Reset && wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got row=%0d data=%0h, required no write",
                         wr_row, wr_data);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                if (e !== {wr_row, wr_data}) begin
                    errors++;
                    $display("FAIL wr_data: got row=%0d data=%0h, required row=%0d data=%0h",
                             wr_row, wr_data, e[EW-1 -: ROW_W], e[X_SIZE*3-1:0]);
                end
            end
        end
    end

    // ---------------- helpers / driver tasks ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic board_row_t tb_empty();
        board_row_t r;
        for (int i = 0; i < X_SIZE; i++) r[i] = EMPTY;
        return r;
    endfunction

    function automatic bit tb_full(input board_row_t r);
        for (int i = 0; i < X_SIZE; i++) if (r[i] == EMPTY) return 1'b0;
        return 1'b1;
    endfunction

    task automatic build_board(input logic [Y_SIZE-1:0] fm, input logic [Y_SIZE-1:0] pm);
        for (int r = 0; r < Y_SIZE; r++) begin
            board_row_t row;
            row = tb_empty();
            if (fm[r]) begin
                for (int i = 0; i < X_SIZE; i++) row[i] = block_color'(3'($urandom_range(7, 1)));
            end else if (pm[r]) begin
                for (int i = 0; i < X_SIZE; i++) row[i] = block_color'(3'($urandom_range(7, 0)));
                row[$urandom_range(X_SIZE - 1, 0)] = EMPTY;
            end
            init_board[r] = row;
        end
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
    endtask

    // Expected final board: survivors keep their order, packed to the bottom.
    // Expected writes are queued in the order the compaction issues them.
    task automatic prep_expect();
        int dst;
        int cnt;
        dst = Y_SIZE - 1;
        cnt = 0;
        for (int r = 0; r < Y_SIZE; r++) exp_board[r] = tb_empty();
        for (int src = Y_SIZE - 1; src >= 0; src--) begin
            if (tb_full(init_board[src])) begin
                cnt++;
            end else begin
                exp_board[dst] = init_board[src];
                if (src != dst) exp_q.push_back({ROW_W'(dst), init_board[src]});
                if (dst > 0) dst--;
            end
        end
        for (int r = cnt - 1; r >= 0; r--) exp_q.push_back({ROW_W'(r), tb_empty()});
    endtask

    task automatic run_pass(input string tag, input int exp_lines, input int exp_lat,
                            input int exp_total, input bit poke_start);
        int cyc;
        int extra;
        prep_expect();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        while (!done && cyc < 100) begin
            start = (poke_start && (cyc == 5 || cyc == 12));
            tick();
            cyc++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_lines_cleared"}, 64'(lines_cleared), 64'(exp_lines));
        check({tag, "_total_lines"}, 64'(total_lines), 64'(exp_total));
        check({tag, "_writes_outstanding"}, 64'(exp_q.size()), 64'd0);
        tick();
        check({tag, "_done_pulse_width"}, 64'(done), 64'd0);
        check({tag, "_busy_after_done"}, 64'(busy), 64'd0);
        check({tag, "_lines_held"}, 64'(lines_cleared), 64'(exp_lines));
        if (poke_start) begin
            extra = 0;
            for (int i = 0; i < 30; i++) begin
                tick();
                if (done || busy) extra++;
            end
            check({tag, "_ignored_start"}, 64'(extra), 64'd0);
        end
        for (int r = 0; r < Y_SIZE; r++) begin
            check($sformatf("%s_board_row%0d", tag, r), 64'(board[r]), 64'(exp_board[r]));
        end
        exp_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [Y_SIZE-1:0] full_mask;
        logic [Y_SIZE-1:0] part_mask;
        int                exp_lines;
        int                exp_lat;
        int                exp_total;
    } vec_t;

    vec_t vecs [7];

    initial begin
        checks = 0;
        errors = 0;
        start  = 1'b0;
        load   = 1'b0;
        Reset  = 1'b1;

        // no full rows, every row partial: board unchanged, no writes
        vecs[0] = '{20'h00000, 20'hFFFFF,  0, 22,  0};
        // row 19 full, rows 17-18 partial
        vecs[1] = '{20'h80000, 20'h60000,  1, 23,  1};
        // rows 16-19 full, row 15 partial (runs after the mid-pass reset)
        vecs[2] = '{20'hF0000, 20'h08000,  4, 26,  4};
        // rows 19 and 17 full, all other rows partial
        vecs[3] = '{20'hA0000, 20'h5FFFF,  2, 24,  6};
        // every row full, twice: second pass saturates the 5-bit total
        vecs[4] = '{20'hFFFFF, 20'h00000, 20, 42, 26};
        vecs[5] = '{20'hFFFFF, 20'h00000, 20, 42, 31};
        // top row and two interior rows full
        vecs[6] = '{20'h01021, 20'hFEFDE,  3, 25, 31};

        #3;
        check("rst_busy",          64'(busy),          64'd0);
        check("rst_done",          64'(done),          64'd0);
        check("rst_wr_en",         64'(wr_en),         64'd0);
        check("rst_rd_row",        64'(rd_row),        64'd0);
        check("rst_wr_row",        64'(wr_row),        64'd0);
        check("rst_wr_data",       64'(wr_data),       64'(tb_empty()));
        check("rst_lines_cleared", 64'(lines_cleared), 64'd0);
        check("rst_total_lines",   64'(total_lines),   64'd0);
        repeat (3) tick();
        Reset = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
            if (v == 2) begin
                // start pulses while busy must be dropped
                build_board(vecs[1].full_mask, vecs[1].part_mask);
                run_pass("busy_start", 1, 23, 2, 1'b1);

                // reset in the middle of SCAN
                build_board(vecs[2].full_mask, vecs[2].part_mask);
                prep_expect();
                start = 1'b1;
                tick();
                start = 1'b0;
                repeat (8) tick();
                check("mid_busy_pre_reset", 64'(busy), 64'd1);
                Reset = 1'b1;
                #1;
                check("mid_rst_busy",        64'(busy),          64'd0);
                check("mid_rst_wr_en",       64'(wr_en),         64'd0);
                check("mid_rst_total_lines", 64'(total_lines),   64'd0);
                check("mid_rst_lines",       64'(lines_cleared), 64'd0);
                check("mid_rst_rd_row",      64'(rd_row),        64'd0);
                exp_q.delete();
                tick();
                Reset = 1'b0;
                tick();
            end
            build_board(vecs[v].full_mask, vecs[v].part_mask);
            run_pass($sformatf("vec%0d", v), vecs[v].exp_lines, vecs[v].exp_lat,
                     vecs[v].exp_total, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
